wt_mem_req_arbiter: RTL and testbench
=====================================

// Module: wt_mem_req_arbiter
// PURPOSE
// - Shares the single cache-to-memory request port between three requesters:
//   instruction cache refill (0), write-through dcache read miss (1) and dcache write buffer (2).
// - Round-robin arbitration, held grant under backpressure and credit-based store throttling.
// - Routes responses back to the requester by transaction ID.
// - Sits between the WT cache subsystem and the AXI/NoC adapter.
// PARAMETERS
// - NR_REQ             3   number of requesters; index 2 is always the store requester
// - ADDR_W             64  request address width
// - DATA_W             64  request write-data width
// - TID_W              2   per-requester transaction ID width
// - MAX_OUT_STORES     7   maximum stores issued but not yet acknowledged
// PORTS
// - clk_i              in   1                  clock
// - rst_ni             in   1                  reset, synchronous, active-low
// - req_valid_i        in   NR_REQ             request valid per requester
// - req_ready_o        out  NR_REQ             request accepted (one-hot or zero)
// - req_addr_i         in   NR_REQ*ADDR_W      packed addresses
// - req_data_i         in   NR_REQ*DATA_W      packed write data (used by index 2 only)
// - req_tid_i          in   NR_REQ*TID_W       packed requester transaction IDs
// - mem_valid_o        out  1                  request valid toward adapter
// - mem_ready_i        in   1                  adapter accepts request
// - mem_addr_o         out  ADDR_W             registered address
// - mem_data_o         out  DATA_W             registered data
// - mem_we_o           out  1                  1 = store request
// - mem_id_o           out  2+TID_W            {source index, tid}
// - rsp_valid_i        in   1                  response/ack from adapter
// - rsp_id_i           in   2+TID_W            ID of the response
// - rsp_valid_o        out  NR_REQ             one-hot routed response strobe
// - rsp_tid_o          out  TID_W              tid field of rsp_id_i
// - store_cnt_o        out  $clog2(MAX_OUT_STORES+1)  outstanding store count
// - stores_pending_o   out  1                  store_cnt_o != 0
// - err_o              out  1                  sticky protocol error
// BEHAVIOUR
// - All outputs reset to 0. The RR pointer resets to requester 0.
//   A reset asserted mid-transfer drops mem_valid_o at the next edge.
// - FSM IDLE/HOLD:
//   - IDLE: pick the first eligible requester at or after the RR pointer.
//     Assert req_ready_o for it in the same cycle (combinational).
//     Register addr/data/we/id; mem_valid_o=1 from the next cycle; go to HOLD.
//   - HOLD: outputs stable while !mem_ready_i.
//     On mem_ready_i: RR pointer = winner+1 (mod NR_REQ).
//     With an eligible request present, accept and reload it in the same cycle
//     (back-to-back, 1 req/cycle throughput). Otherwise go to IDLE and drop mem_valid_o.
// - Request-to-mem_valid_o latency: 1 cycle.
// - Eligibility:
//   - Requester 2 is masked while store_cnt_o == MAX_OUT_STORES.
//   - Requester 2 is also masked while the count equals MAX-1 and a store sits unaccepted in HOLD.
// - Store counter:
//   - +1 on mem handshake with mem_we_o.
//   - -1 on rsp_valid_i with rsp_id_i[src]==2.
//   - Both in the same cycle: unchanged.
//   - An ack at count 0 holds the count at 0 and sets err_o.
// - Response routing:
//   - rsp_valid_o[rsp_id_i src field] = rsp_valid_i, combinational (0 cycles).
//   - A src field >= NR_REQ sets err_o and routes nowhere.
// - Only a reset clears err_o.
// CONFIGURATION
// - WT_ARB_FENCE_DRAIN_EN defined: adds input fence_i and output fence_done_o.
//   - While fence_i=1, requesters 0 and 1 are masked.
//   - fence_done_o=1 when fence_i=1, store_cnt_o==0 and no store is in HOLD (registered, 1 cycle).
// - Macro undefined: these ports do not exist; reads are never masked.
// TESTING
// - Single icache req addr 0x8000_0000 -> mem_valid_o next cycle, mem_id_o src=0; req_ready_o[0] pulses one cycle.
// - All three valid continuously, mem_ready_i=1 -> grants 0,1,2,0,1,2 on consecutive cycles.
// - mem_ready_i held 0 for 5 cycles -> mem_addr_o/mem_id_o unchanged; no other req_ready_o asserted.
// - 8 stores with no acks -> 7 issued, 8th stalled, store_cnt_o=7.
//   One ack -> 8th issues next cycle, count returns to 7.
// - Store handshake and ack in the same cycle at count 3 -> count stays 3.
//   Ack at count 0 -> err_o=1, count stays 0.
// - (WT_ARB_FENCE_DRAIN_EN) fence_i=1 with 2 stores pending -> reads blocked.
//   After 2 acks -> fence_done_o=1 one cycle later.

Source files
------------

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing the cache-to-memory request port, with store credit throttling
// and ID-based response routing. Define WT_ARB_FENCE_DRAIN_EN to add fence_i/fence_done_o.
module wt_mem_req_arbiter #(
    parameter int  NR_REQ         = 3,
    parameter int  ADDR_W         = 64,
    parameter int  DATA_W         = 64,
    parameter int  TID_W          = 2,
    parameter int  MAX_OUT_STORES = 7,
    localparam int CNT_W          = $clog2(MAX_OUT_STORES + 1),
    localparam int ID_W           = 2 + TID_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
`ifdef WT_ARB_FENCE_DRAIN_EN
    input  logic                     fence_i,
    output logic                     fence_done_o,
`endif
    input  logic [NR_REQ-1:0]        req_valid_i,
    output logic [NR_REQ-1:0]        req_ready_o,
    input  logic [NR_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NR_REQ*DATA_W-1:0] req_data_i,
    input  logic [NR_REQ*TID_W-1:0]  req_tid_i,
    output logic                     mem_valid_o,
    input  logic                     mem_ready_i,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_data_o,
    output logic                     mem_we_o,
    output logic [ID_W-1:0]          mem_id_o,
    input  logic                     rsp_valid_i,
    input  logic [ID_W-1:0]          rsp_id_i,
    output logic [NR_REQ-1:0]        rsp_valid_o,
    output logic [TID_W-1:0]         rsp_tid_o,
    output logic [CNT_W-1:0]         store_cnt_o,
    output logic                     stores_pending_o,
    output logic                     err_o
);
    localparam int SRC_W     = 2;
    localparam int STORE_IDX = 2;

    typedef enum logic {IDLE, HOLD} state_e;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              we;
        logic [ID_W-1:0]   id;
    } mem_req_t;

    state_e   state_q, state_d;
    mem_req_t req_q, req_d;

    logic [NR_REQ-1:0][ADDR_W-1:0] addr_lane;
    logic [NR_REQ-1:0][DATA_W-1:0] data_lane;
    logic [NR_REQ-1:0][TID_W-1:0]  tid_lane;
    logic [NR_REQ-1:0]             eligible;
    logic [SRC_W-1:0]              rr_q, ptr, cand, grant, held_src, held_next, rsp_src;
    logic found, accept, handshake, hold_store, store_block, inc, dec, rsp_bad;

    assign addr_lane = req_addr_i;
    assign data_lane = req_data_i;
    assign tid_lane  = req_tid_i;

    assign held_src    = req_q.id[ID_W-1 -: SRC_W];
    assign held_next   = (held_src == SRC_W'(NR_REQ - 1)) ? '0 : held_src + 1'b1;
    assign handshake   = (state_q == HOLD) && mem_ready_i;
    assign hold_store  = (state_q == HOLD) && req_q.we;
    // Counted stores plus the one waiting in HOLD never exceed the credit limit.
    assign store_block = (store_cnt_o == CNT_W'(MAX_OUT_STORES)) ||
                         ((store_cnt_o == CNT_W'(MAX_OUT_STORES - 1)) && hold_store);

    always_comb begin
        eligible = req_valid_i;
        if (store_block) eligible[STORE_IDX] = 1'b0;
`ifdef WT_ARB_FENCE_DRAIN_EN
        if (fence_i) begin
            eligible[0] = 1'b0;
            eligible[1] = 1'b0;
        end
`endif
        // During a handshake the pointer advance is applied early so back-to-back grants rotate.
        ptr   = handshake ? held_next : rr_q;
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            cand = SRC_W'((int'(ptr) + i) % NR_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
        accept = rst_ni && found && ((state_q == IDLE) || mem_ready_i);

        req_ready_o = '0;
        req_d       = req_q;
        if (accept) begin
            req_ready_o[grant] = 1'b1;
            req_d.addr = addr_lane[grant];
            req_d.data = data_lane[grant];
            req_d.we   = (grant == SRC_W'(STORE_IDX));
            req_d.id   = {grant, tid_lane[grant]};
        end

        state_d = state_q;
        if (accept)         state_d = HOLD;
        else if (handshake) state_d = IDLE;
    end

    assign mem_valid_o      = (state_q == HOLD);
    assign mem_addr_o       = req_q.addr;
    assign mem_data_o       = req_q.data;
    assign mem_we_o         = req_q.we;
    assign mem_id_o         = req_q.id;
    assign stores_pending_o = |store_cnt_o;

    assign rsp_src   = rsp_id_i[ID_W-1 -: SRC_W];
    assign rsp_bad   = int'(rsp_src) >= NR_REQ;
    assign rsp_tid_o = rsp_id_i[TID_W-1:0];
    assign inc       = handshake && req_q.we;
    assign dec       = rsp_valid_i && (rsp_src == SRC_W'(STORE_IDX));

    always_comb begin
        rsp_valid_o = '0;
        if (rst_ni && rsp_valid_i && !rsp_bad) rsp_valid_o[rsp_src] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rr_q        <= '0;
            store_cnt_o <= '0;
            err_o       <= 1'b0;
`ifdef WT_ARB_FENCE_DRAIN_EN
            fence_done_o <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            if (handshake) rr_q <= held_next;
            if (inc && !dec) begin
                store_cnt_o <= store_cnt_o + 1'b1;
            end else if (dec && !inc) begin
                if (store_cnt_o == '0) err_o <= 1'b1;
                else                   store_cnt_o <= store_cnt_o - 1'b1;
            end
            if (rsp_valid_i && rsp_bad) err_o <= 1'b1;
`ifdef WT_ARB_FENCE_DRAIN_EN
            fence_done_o <= fence_i && (store_cnt_o == '0) && !hold_store;
`endif
        end
    end
endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Self-checking bench for wt_mem_req_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_wt_mem_req_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
`ifdef WT_ARB_FENCE_DRAIN_EN
    logic         fence_i, fence_done;
`endif
    logic [2:0]   req_valid, req_ready;
    logic [191:0] req_addr, req_data;
    logic [5:0]   req_tid;
    logic         mem_valid, mem_ready, mem_we;
    logic [63:0]  mem_addr, mem_data;
    logic [3:0]   mem_id, rsp_id;
    logic         rsp_valid_i;
    logic [2:0]   rsp_valid_o;
    logic [1:0]   rsp_tid;
    logic [2:0]   store_cnt;
    logic         pending, err;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wt_mem_req_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
`ifdef WT_ARB_FENCE_DRAIN_EN
        .fence_i(fence_i), .fence_done_o(fence_done),
`endif
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_tid_i(req_tid),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_data_o(mem_data), .mem_we_o(mem_we), .mem_id_o(mem_id),
        .rsp_valid_i(rsp_valid_i), .rsp_id_i(rsp_id), .rsp_valid_o(rsp_valid_o),
        .rsp_tid_o(rsp_tid), .store_cnt_o(store_cnt), .stores_pending_o(pending), .err_o(err)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_addr = '0; req_data = '0; req_tid = '0;
        mem_ready = 1'b0; rsp_valid_i = 1'b0; rsp_id = '0;
`ifdef WT_ARB_FENCE_DRAIN_EN
        fence_i = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        #1;
        n_total++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid got=%b want=0", mem_valid); else n_pass++;
        n_total++; if (req_ready !== 3'b000) $display("FAIL rst_req_ready got=%b want=000", req_ready); else n_pass++;
        n_total++; if ({mem_addr, mem_id, mem_we} !== '0) $display("FAIL rst_mem_fields got=%h/%h/%b want=0", mem_addr, mem_id, mem_we); else n_pass++;
        n_total++; if ({store_cnt, pending, err} !== 5'b0) $display("FAIL rst_cnt_err got=%0d/%b/%b want=0", store_cnt, pending, err); else n_pass++;
        rst_n = 1'b1;
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        #1;
        n_total++; if (mem_valid !== 1'b1) $display("FAIL midrst_pre got=%b want=1", mem_valid); else n_pass++;
        rst_n = 1'b0;
        tick();
        #1;
        n_total++; if (mem_valid !== 1'b0) $display("FAIL midrst_drop got=%b want=0", mem_valid); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 3'b001;
        req_addr[63:0] = 64'h8000_0000;
        req_tid[1:0] = 2'd1;
        #1;
        n_total++; if (req_ready !== 3'b001) $display("FAIL single_ready got=%b want=001", req_ready); else n_pass++;
        n_total++; if (mem_valid !== 1'b0) $display("FAIL single_early_valid got=%b want=0", mem_valid); else n_pass++;
        tick();
        req_valid = 3'b000;
        #1;
        n_total++; if (mem_valid !== 1'b1) $display("FAIL single_valid got=%b want=1", mem_valid); else n_pass++;
        n_total++; if (mem_addr !== 64'h8000_0000) $display("FAIL single_addr got=%h want=80000000", mem_addr); else n_pass++;
        n_total++; if ({mem_id, mem_we} !== 5'b0001_0) $display("FAIL single_id_we got=%h/%b want=1/0", mem_id, mem_we); else n_pass++;
        n_total++; if (req_ready !== 3'b000) $display("FAIL single_ready_pulse got=%b want=000", req_ready); else n_pass++;
        mem_ready = 1'b1;
        tick();
        #1;
        n_total++; if (mem_valid !== 1'b0) $display("FAIL single_idle got=%b want=0", mem_valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        do_reset();
        for (int j = 0; j < 3; j++) req_addr[j*64 +: 64] = 64'h1000 * (j + 1);
        req_valid = 3'b111;
        mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp = '0;
            exp[k % 3] = 1'b1;
            n_total++; if (req_ready !== exp) $display("FAIL rr_grant%0d got=%b want=%b", k, req_ready, exp); else n_pass++;
            if (k > 0) begin
                n_total++; if (int'(mem_id[3:2]) != (k - 1) % 3) $display("FAIL rr_src%0d got=%0d want=%0d", k, mem_id[3:2], (k - 1) % 3); else n_pass++;
            end
            tick();
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int j = 0; j < 3; j++) begin
            req_addr[j*64 +: 64] = 64'hA000 + j;
            req_tid[j*2 +: 2] = 2'(j + 1);
        end
        req_valid = 3'b111;
        #1;
        n_total++; if (req_ready !== 3'b001) $display("FAIL bp_first got=%b want=001", req_ready); else n_pass++;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++; if (req_ready !== 3'b000) $display("FAIL bp_ready%0d got=%b want=000", k, req_ready); else n_pass++;
            n_total++; if ({mem_valid, mem_addr, mem_id} !== {1'b1, 64'hA000, 4'b0001}) $display("FAIL bp_hold%0d got=%b/%h/%h want=1/a000/1", k, mem_valid, mem_addr, mem_id); else n_pass++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        n_total++; if (req_ready !== 3'b010) $display("FAIL bp_release got=%b want=010", req_ready); else n_pass++;
        tick();
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_store_throttle();
        logic [2:0] exp;
        do_reset();
        req_valid = 3'b100;
        req_tid[5:4] = 2'd3;
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp = (k <= 6) ? 3'b100 : 3'b000;
            n_total++; if (req_ready !== exp) $display("FAIL thr_ready%0d got=%b want=%b", k, req_ready, exp); else n_pass++;
            tick();
        end
        #1;
        n_total++; if ({store_cnt, mem_valid, pending} !== {3'd7, 1'b0, 1'b1}) $display("FAIL thr_sat got=%0d/%b/%b want=7/0/1", store_cnt, mem_valid, pending); else n_pass++;
        rsp_valid_i = 1'b1;
        rsp_id = 4'b1011;
        #1;
        n_total++; if ({rsp_valid_o, rsp_tid} !== {3'b100, 2'd3}) $display("FAIL thr_ack_route got=%b/%0d want=100/3", rsp_valid_o, rsp_tid); else n_pass++;
        n_total++; if (req_ready !== 3'b000) $display("FAIL thr_ack_ready got=%b want=000", req_ready); else n_pass++;
        tick();
        rsp_valid_i = 1'b0;
        #1;
        n_total++; if ({store_cnt, req_ready} !== {3'd6, 3'b100}) $display("FAIL thr_reissue got=%0d/%b want=6/100", store_cnt, req_ready); else n_pass++;
        tick();
        #1;
        n_total++; if ({mem_valid, req_ready} !== {1'b1, 3'b000}) $display("FAIL thr_hold got=%b/%b want=1/000", mem_valid, req_ready); else n_pass++;
        tick();
        #1;
        n_total++; if ({store_cnt, mem_valid} !== {3'd7, 1'b0}) $display("FAIL thr_back7 got=%0d/%b want=7/0", store_cnt, mem_valid); else n_pass++;
        req_valid = 3'b000;
    endtask

    task automatic test_same_cycle_and_underflow();
        do_reset();
        req_valid = 3'b100;
        mem_ready = 1'b1;
        repeat (3) tick();
        req_valid = 3'b000;
        tick();
        #1;
        n_total++; if (store_cnt !== 3'd3) $display("FAIL sc_setup got=%0d want=3", store_cnt); else n_pass++;
        req_valid = 3'b100;
        mem_ready = 1'b0;
        tick();
        req_valid = 3'b000;
        mem_ready = 1'b1;
        rsp_valid_i = 1'b1;
        rsp_id = 4'b1000;
        tick();
        rsp_valid_i = 1'b0;
        #1;
        n_total++; if ({store_cnt, err, mem_valid} !== {3'd3, 1'b0, 1'b0}) $display("FAIL sc_both got=%0d/%b/%b want=3/0/0", store_cnt, err, mem_valid); else n_pass++;
        rsp_valid_i = 1'b1;
        repeat (3) tick();
        rsp_valid_i = 1'b0;
        #1;
        n_total++; if ({store_cnt, err} !== {3'd0, 1'b0}) $display("FAIL sc_drain got=%0d/%b want=0/0", store_cnt, err); else n_pass++;
        rsp_valid_i = 1'b1;
        tick();
        rsp_valid_i = 1'b0;
        #1;
        n_total++; if ({store_cnt, pending, err} !== {3'd0, 1'b0, 1'b1}) $display("FAIL sc_underflow got=%0d/%b/%b want=0/0/1", store_cnt, pending, err); else n_pass++;
    endtask

    task automatic test_bad_src();
        do_reset();
        rsp_valid_i = 1'b1;
        rsp_id = 4'b0110;
        #1;
        n_total++; if ({rsp_valid_o, rsp_tid} !== {3'b010, 2'b10}) $display("FAIL route_src1 got=%b/%b want=010/10", rsp_valid_o, rsp_tid); else n_pass++;
        rsp_id = 4'b1110;
        #1;
        n_total++; if ({rsp_valid_o, err} !== 4'b0000) $display("FAIL bad_src_route got=%b/%b want=000/0", rsp_valid_o, err); else n_pass++;
        tick();
        rsp_valid_i = 1'b0;
        repeat (3) tick();
        #1;
        n_total++; if (err !== 1'b1) $display("FAIL bad_src_sticky got=%b want=1", err); else n_pass++;
        do_reset();
        #1;
        n_total++; if (err !== 1'b0) $display("FAIL bad_src_clear got=%b want=0", err); else n_pass++;
    endtask

`ifdef WT_ARB_FENCE_DRAIN_EN
    task automatic test_fence();
        do_reset();
        req_valid = 3'b100;
        mem_ready = 1'b1;
        repeat (2) tick();
        req_valid = 3'b000;
        tick();
        fence_i = 1'b1;
        req_valid = 3'b011;
        #1;
        n_total++; if ({store_cnt, req_ready, fence_done} !== {3'd2, 3'b000, 1'b0}) $display("FAIL fence_block got=%0d/%b/%b want=2/000/0", store_cnt, req_ready, fence_done); else n_pass++;
        rsp_valid_i = 1'b1;
        rsp_id = 4'b1000;
        repeat (2) tick();
        rsp_valid_i = 1'b0;
        #1;
        n_total++; if ({store_cnt, fence_done, req_ready} !== {3'd0, 1'b0, 3'b000}) $display("FAIL fence_drain got=%0d/%b/%b want=0/0/000", store_cnt, fence_done, req_ready); else n_pass++;
        tick();
        #1;
        n_total++; if (fence_done !== 1'b1) $display("FAIL fence_done got=%b want=1", fence_done); else n_pass++;
        fence_i = 1'b0;
        #1;
        n_total++; if (req_ready !== 3'b001) $display("FAIL fence_release got=%b want=001", req_ready); else n_pass++;
        tick();
        req_valid = 3'b000;
        tick();
    endtask
`endif

    // Reference: a request slot (held or empty), a rotating priority start and a store credit count.
    task automatic test_random();
        int m_hold, m_src, m_rr, m_cnt, m_err, m_we, m_tid;
        int grant, ptr, hs, blk, inc, dec;
        logic [63:0] m_addr;
        logic [2:0]  exp_ready, exp_rsp;
        int r;
        do_reset();
        m_hold = 0; m_src = 0; m_rr = 0; m_cnt = 0; m_err = 0; m_we = 0; m_tid = 0; m_addr = '0;
        for (int c = 0; c < 400; c++) begin
            req_valid = 3'($urandom);
            req_addr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            req_tid = 6'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 3);
            rsp_valid_i = 1'b0;
            rsp_id = '0;
            if (r == 0 && m_cnt > 0) begin
                rsp_valid_i = 1'b1;
                rsp_id = {2'd2, 2'($urandom)};
            end else if (r == 1) begin
                rsp_valid_i = 1'b1;
                rsp_id = {1'b0, 1'($urandom), 2'($urandom)};
            end
            #1;
            hs  = (m_hold != 0 && mem_ready) ? 1 : 0;
            ptr = (hs != 0) ? (m_src + 1) % 3 : m_rr;
            blk = (m_cnt == 7 || (m_cnt == 6 && m_hold != 0 && m_we != 0)) ? 1 : 0;
            grant = -1;
            for (int i = 0; i < 3; i++) begin
                int j;
                j = (ptr + i) % 3;
                if (grant < 0 && req_valid[j] && !(j == 2 && blk != 0)) grant = j;
            end
            exp_ready = '0;
            if (grant >= 0 && (m_hold == 0 || mem_ready)) exp_ready[grant] = 1'b1;
            exp_rsp = '0;
            if (rsp_valid_i) exp_rsp[rsp_id[3:2]] = 1'b1;

            n_total++; if (req_ready !== exp_ready) $display("FAIL rnd_ready c%0d got=%b want=%b", c, req_ready, exp_ready); else n_pass++;
            n_total++; if (mem_valid !== 1'(m_hold)) $display("FAIL rnd_valid c%0d got=%b want=%0d", c, mem_valid, m_hold); else n_pass++;
            if (m_hold != 0) begin
                n_total++; if ({mem_addr, mem_id, mem_we} !== {m_addr, 2'(m_src), 2'(m_tid), 1'(m_we)}) $display("FAIL rnd_req c%0d got=%h/%h/%b want=%h/%0d%0d/%0d", c, mem_addr, mem_id, mem_we, m_addr, m_src, m_tid, m_we); else n_pass++;
            end
            n_total++; if ({store_cnt, err} !== {3'(m_cnt), 1'(m_err)}) $display("FAIL rnd_cnt c%0d got=%0d/%b want=%0d/%0d", c, store_cnt, err, m_cnt, m_err); else n_pass++;
            n_total++; if (rsp_valid_o !== exp_rsp) $display("FAIL rnd_rsp c%0d got=%b want=%b", c, rsp_valid_o, exp_rsp); else n_pass++;

            inc = (hs != 0 && m_we != 0) ? 1 : 0;
            dec = (rsp_valid_i && rsp_id[3:2] == 2'd2) ? 1 : 0;
            if (inc != 0 && dec == 0) m_cnt++;
            else if (dec != 0 && inc == 0) begin
                if (m_cnt == 0) m_err = 1;
                else m_cnt--;
            end
            if (hs != 0) m_rr = (m_src + 1) % 3;
            if (exp_ready != 3'b000) begin
                m_hold = 1;
                m_src  = grant;
                m_addr = req_addr[grant*64 +: 64];
                m_tid  = int'(req_tid[grant*2 +: 2]);
                m_we   = (grant == 2) ? 1 : 0;
            end else if (hs != 0) begin
                m_hold = 0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_store_throttle();
        test_same_cycle_and_underflow();
        test_bad_src();
`ifdef WT_ARB_FENCE_DRAIN_EN
        test_fence();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
